// File: rtl/multi_pulse_generator.sv
// N_CH-channel PPS-aligned pulse train generator armed by a Thunderbolt time-of-day match.
// Optional build macro PULSE_GEN_PPS_RESYNC_EN: PPS edges realign running channels.
module multi_pulse_generator #(
    parameter int N_CH          = 4,
    parameter int CLKS_PER_1_US = 10,
    parameter int CNT_W         = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pps_raw,
    input  logic [N_CH-1:0]         i_ch_enable,
    input  logic [15:0]             i_usr_year,
    input  logic [7:0]              i_usr_month,
    input  logic [7:0]              i_usr_day,
    input  logic [7:0]              i_usr_hour,
    input  logic [7:0]              i_usr_minutes,
    input  logic [7:0]              i_usr_seconds,
    input  logic                    i_thunder_packet_dv,
    input  logic [15:0]             i_thunder_year,
    input  logic [7:0]              i_thunder_month,
    input  logic [7:0]              i_thunder_day,
    input  logic [7:0]              i_thunder_hour,
    input  logic [7:0]              i_thunder_minutes,
    input  logic [7:0]              i_thunder_seconds,
    input  logic [N_CH*CNT_W-1:0]   i_width_high,
    input  logic [N_CH*CNT_W-1:0]   i_width_period,
    input  logic [N_CH*CNT_W-1:0]   i_offset,
    input  logic [N_CH*16-1:0]      i_pulse_count,
    output logic [N_CH-1:0]         o_pulse_out,
    output logic [N_CH-1:0]         o_ch_running,
    output logic [N_CH-1:0]         o_ch_done
);

    // state    | meaning
    // IDLE     | channel disabled, counters cleared
    // ARMED    | waiting for a Thunderbolt time-of-day match
    // WAIT_PPS | matched, waiting for the next PPS rising edge
    // DELAY    | counting the per-channel microsecond offset
    // RUN      | emitting the periodic pulse train
    // DONE     | pulse count reached, output held low
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_PPS,
        S_DELAY,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CLK_W = (CLKS_PER_1_US > 1) ? $clog2(CLKS_PER_1_US) : 1;
    localparam logic [CLK_W-1:0] CLK_MAX = CLK_W'(CLKS_PER_1_US - 1);

    logic [1:0] pps_sr;
    logic       pps_edge;
    logic       tod_hit;

    // Edge flag is registered so every channel sees the same fixed latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pps_sr   <= 2'b00;
            pps_edge <= 1'b0;
        end else begin
            pps_sr   <= {pps_sr[0], i_pps_raw};
            pps_edge <= (pps_sr == 2'b01);
        end
    end

    assign tod_hit = i_thunder_packet_dv
                   && (i_thunder_year    == i_usr_year)
                   && (i_thunder_month   == i_usr_month)
                   && (i_thunder_day     == i_usr_day)
                   && (i_thunder_hour    == i_usr_hour)
                   && (i_thunder_minutes == i_usr_minutes)
                   && (i_thunder_seconds == i_usr_seconds);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t           state;
        logic [CLK_W-1:0] clk_cnt;
        logic [CNT_W-1:0] us_cnt;
        logic [CNT_W-1:0] off_cnt;
        logic [15:0]      pulse_cnt;
        logic             pulse_q;

        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] period_eff;
        logic [CNT_W-1:0] offset;
        logic [15:0]      count_lim;
        logic [CNT_W:0]   off_next;
        logic [15:0]      pulse_next;
        logic             us_tick;
        logic             us_wrap;

        assign width      = i_width_high[k*CNT_W +: CNT_W];
        assign period     = i_width_period[k*CNT_W +: CNT_W];
        assign offset     = i_offset[k*CNT_W +: CNT_W];
        assign count_lim  = i_pulse_count[k*16 +: 16];
        assign period_eff = (period == '0) ? CNT_W'(1) : period;
        assign off_next   = {1'b0, off_cnt} + 1'b1;
        assign pulse_next = pulse_cnt + 16'd1;
        assign us_tick    = (clk_cnt == CLK_MAX);
        // >= keeps a live period reduction from running the counter past the end.
        assign us_wrap    = us_tick && (us_cnt >= (period_eff - 1'b1));

        always_ff @(posedge i_clk) begin
            if (i_rst || !i_ch_enable[k]) begin
                state     <= S_IDLE;
                clk_cnt   <= '0;
                us_cnt    <= '0;
                off_cnt   <= '0;
                pulse_cnt <= '0;
                pulse_q   <= 1'b0;
            end else begin
                pulse_q <= (state == S_RUN) && (us_cnt < width);
                case (state)
                    S_IDLE: state <= S_ARMED;
                    S_ARMED: begin
                        if (tod_hit) state <= S_WAIT_PPS;
                    end
                    S_WAIT_PPS: begin
                        if (pps_edge) begin
                            clk_cnt   <= '0;
                            us_cnt    <= '0;
                            off_cnt   <= '0;
                            pulse_cnt <= '0;
                            state     <= (offset != '0) ? S_DELAY : S_RUN;
                        end
                    end
                    S_DELAY: begin
                        clk_cnt <= us_tick ? '0 : clk_cnt + 1'b1;
                        if (us_tick) begin
                            if (off_next >= {1'b0, offset}) begin
                                off_cnt <= '0;
                                us_cnt  <= '0;
                                state   <= S_RUN;
                            end else begin
                                off_cnt <= off_next[CNT_W-1:0];
                            end
                        end
                    end
                    S_RUN: begin
                        clk_cnt <= us_tick ? '0 : clk_cnt + 1'b1;
                        if (us_wrap) begin
                            us_cnt    <= '0;
                            pulse_cnt <= pulse_next;
                            if ((count_lim != 16'd0) && (pulse_next >= count_lim))
                                state <= S_DONE;
                        end else if (us_tick) begin
                            us_cnt <= us_cnt + 1'b1;
                        end
`ifdef PULSE_GEN_PPS_RESYNC_EN
                        if (pps_edge) begin
                            clk_cnt <= '0;
                            us_cnt  <= '0;
                            off_cnt <= '0;
                        end
`endif
                    end
                    S_DONE: state <= S_DONE;
                    default: state <= S_IDLE;
                endcase
            end
        end

        assign o_pulse_out[k]  = pulse_q;
        assign o_ch_running[k] = (state == S_DELAY) || (state == S_RUN);
        assign o_ch_done[k]    = (state == S_DONE);
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator; expected values are hand-computed timelines.
// PPS rising sampled first at edge E0 -> output high after E3 for offset 0.
module tb_multi_pulse_generator;

    localparam int N_CH  = 4;
    localparam int CPU   = 10;
    localparam int CNT_W = 24;
`ifdef PULSE_GEN_PPS_RESYNC_EN
    localparam logic RESYNC = 1'b1;
`else
    localparam logic RESYNC = 1'b0;
`endif

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_pps_raw;
    logic [N_CH-1:0]       i_ch_enable;
    logic [15:0]           i_usr_year;
    logic [7:0]            i_usr_month, i_usr_day, i_usr_hour, i_usr_minutes, i_usr_seconds;
    logic                  i_thunder_packet_dv;
    logic [15:0]           i_thunder_year;
    logic [7:0]            i_thunder_month, i_thunder_day, i_thunder_hour, i_thunder_minutes, i_thunder_seconds;
    logic [N_CH*CNT_W-1:0] i_width_high, i_width_period, i_offset;
    logic [N_CH*16-1:0]    i_pulse_count;
    logic [N_CH-1:0]       o_pulse_out, o_ch_running, o_ch_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int r0, r1, r2;
    logic [3:0] prev, cur;

    multi_pulse_generator #(.N_CH(N_CH), .CLKS_PER_1_US(CPU), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pps_raw(i_pps_raw), .i_ch_enable(i_ch_enable),
        .i_usr_year(i_usr_year), .i_usr_month(i_usr_month), .i_usr_day(i_usr_day),
        .i_usr_hour(i_usr_hour), .i_usr_minutes(i_usr_minutes), .i_usr_seconds(i_usr_seconds),
        .i_thunder_packet_dv(i_thunder_packet_dv), .i_thunder_year(i_thunder_year),
        .i_thunder_month(i_thunder_month), .i_thunder_day(i_thunder_day),
        .i_thunder_hour(i_thunder_hour), .i_thunder_minutes(i_thunder_minutes),
        .i_thunder_seconds(i_thunder_seconds),
        .i_width_high(i_width_high), .i_width_period(i_width_period), .i_offset(i_offset),
        .i_pulse_count(i_pulse_count),
        .o_pulse_out(o_pulse_out), .o_ch_running(o_ch_running), .o_ch_done(o_ch_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input int w, input int p, input int off, input int cnt);
        i_width_high[k*CNT_W +: CNT_W]   = CNT_W'(w);
        i_width_period[k*CNT_W +: CNT_W] = CNT_W'(p);
        i_offset[k*CNT_W +: CNT_W]       = CNT_W'(off);
        i_pulse_count[k*16 +: 16]        = 16'(cnt);
    endtask

    task automatic send_tod(input logic [15:0] yr);
        i_thunder_year      = yr;
        i_thunder_packet_dv = 1'b1;
        tick();
        i_thunder_packet_dv = 1'b0;
    endtask

    // Drops PPS long enough to clear the shift register, then raises it; returns just after E0.
    task automatic pps_rise();
        i_pps_raw = 1'b0;
        repeat (3) tick();
        i_pps_raw = 1'b1;
        tick();
    endtask

    initial begin
        i_rst = 1'b1;
        i_pps_raw = 1'b0;
        i_ch_enable = '0;
        i_usr_year = 16'd2025; i_usr_month = 8'd6; i_usr_day = 8'd15;
        i_usr_hour = 8'd12; i_usr_minutes = 8'd30; i_usr_seconds = 8'd45;
        i_thunder_packet_dv = 1'b0;
        i_thunder_year = 16'd2025; i_thunder_month = 8'd6; i_thunder_day = 8'd15;
        i_thunder_hour = 8'd12; i_thunder_minutes = 8'd30; i_thunder_seconds = 8'd45;
        i_width_high = '0; i_width_period = '0; i_offset = '0; i_pulse_count = '0;
        repeat (3) tick();
        check("rst_pulse", 32'(o_pulse_out), 0);
        check("rst_running", 32'(o_ch_running), 0);
        check("rst_done", 32'(o_ch_done), 0);
        i_rst = 1'b0;

        set_ch(0, 2, 5, 0, 0);
        set_ch(1, 2, 5, 3, 0);
        set_ch(2, 2, 5, 0, 3);
        set_ch(3, 0, 0, 0, 0);
        i_ch_enable = 4'b0111;
        tick();

        // Year mismatch: PPS must not start anything.
        send_tod(16'd2024);
        i_pps_raw = 1'b1;
        repeat (5) tick();
        i_pps_raw = 1'b0;
        repeat (60) tick();
        check("mismatch_pulse", 32'(o_pulse_out), 0);
        check("mismatch_running", 32'(o_ch_running), 0);

        send_tod(16'd2025);
        repeat (30) tick();
        check("matched_no_pps_running", 32'(o_ch_running), 0);
        check("matched_no_pps_pulse", 32'(o_pulse_out), 0);

        i_pps_raw = 1'b1;
        tick();                     // E0
        tick();                     // E1
        tick();                     // E2
        check("e2_running", 32'(o_ch_running), 32'h7);
        check("e2_pulse", 32'(o_pulse_out), 0);

        prev = 4'b0000; r0 = 0; r1 = 0; r2 = 0;
        for (int n = 3; n <= 185; n++) begin
            tick();
            cur = o_pulse_out;
            if (cur[0] && !prev[0]) r0++;
            if (cur[1] && !prev[1]) r1++;
            if (cur[2] && !prev[2]) r2++;
            prev = cur;
            case (n)
                3:   check("e3_first_rise", 32'(cur), 32'h5);
                22:  check("e22_high_end", 32'(cur), 32'h5);
                23:  check("e23_low", 32'(cur), 32'h0);
                32:  check("e32_ch1_not_yet", 32'(cur), 32'h0);
                33:  check("e33_ch1_rise", 32'(cur), 32'h2);
                52:  check("e52_ch1_high", 32'(cur), 32'h2);
                53:  check("e53_period", 32'(cur), 32'h5);
                151: check("e151_done", 32'(o_ch_done), 32'h0);
                152: check("e152_done", 32'(o_ch_done), 32'h4);
                153: check("e153_ch2_quiet", 32'(cur), 32'h1);
                185: check("e185_pulse", 32'(cur), 32'h2);
                default: ;
            endcase
        end
        check("rises_ch0", 32'(r0), 4);
        check("rises_ch1", 32'(r1), 4);
        check("rises_ch2_count", 32'(r2), 3);

        i_ch_enable = 4'b0011;
        tick();
        check("en_low_done_clear", 32'(o_ch_done), 0);
        check("en_low_others_run", 32'(o_pulse_out), 32'h2);
        i_ch_enable = 4'b0111;
        tick();

        i_rst = 1'b1;
        tick();
        check("midrun_rst_pulse", 32'(o_pulse_out), 0);
        check("midrun_rst_running", 32'(o_ch_running), 0);
        check("midrun_rst_done", 32'(o_ch_done), 0);
        i_ch_enable = 4'b0100;
        i_rst = 1'b0;
        tick();

        // tod_hit coincident with the registered PPS edge: must wait for the next edge.
        pps_rise();                 // E0
        tick();                     // E1
        i_thunder_packet_dv = 1'b1;
        i_thunder_year = 16'd2025;
        tick();                     // E2, tod_hit and edge together
        i_thunder_packet_dv = 1'b0;
        repeat (20) tick();
        check("same_cycle_waits", 32'(o_ch_running), 0);
        pps_rise();                 // E0
        tick();
        tick();
        check("rearm_running", 32'(o_ch_running), 32'h4);
        tick();
        check("rearm_rise", 32'(o_pulse_out), 32'h4);
        tick();
        check("rearm_high", 32'(o_pulse_out), 32'h4);
        i_ch_enable = 4'b0000;
        tick();
        check("en_drop_pulse", 32'(o_pulse_out), 0);
        check("en_drop_running", 32'(o_ch_running), 0);

        // Boundaries: ch0 width 0 never high, ch3 period 0 (as 1) with width 4 always high.
        set_ch(0, 0, 5, 0, 0);
        set_ch(3, 4, 0, 0, 0);
        i_ch_enable = 4'b1001;
        tick();
        send_tod(16'd2025);
        pps_rise();                 // E0
        for (int n = 1; n <= 60; n++) begin
            tick();
            case (n)
                2:  check("bnd_e2", 32'(o_pulse_out), 0);
                3:  check("bnd_e3", 32'(o_pulse_out), 32'h8);
                30: check("bnd_e30", 32'(o_pulse_out), 32'h8);
                60: check("bnd_e60", 32'(o_pulse_out), 32'h8);
                default: ;
            endcase
        end
        check("bnd_running", 32'(o_ch_running), 32'h9);

        // Early PPS while running: ignored unless resync is built in.
        i_ch_enable = 4'b0000;
        tick();
        set_ch(1, 2, 3, 0, 0);
        i_ch_enable = 4'b0010;
        tick();
        send_tod(16'd2025);
        pps_rise();                 // E0
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (n == 10) i_pps_raw = 1'b0;
            if (n == 39) i_pps_raw = 1'b1;
            case (n)
                3:  check("rs_e3", 32'(o_pulse_out), 32'h2);
                22: check("rs_e22", 32'(o_pulse_out), 32'h2);
                23: check("rs_e23", 32'(o_pulse_out), 32'h0);
                45: check("rs_e45", 32'(o_pulse_out), 32'h2);
                55: check("rs_e55", 32'(o_pulse_out), RESYNC ? 32'h2 : 32'h0);
                65: check("rs_e65", 32'(o_pulse_out), RESYNC ? 32'h0 : 32'h2);
                default: ;
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
